// File: rtl/ras.sv
// Return-address stack: a circular buffer of return targets with a top pointer and
// occupancy count. The current ptr/count pair is output as a checkpoint that can be restored later.
module ras #(
  parameter int RAS_DEPTH        = 8,
  parameter int RAS_TARGET_WIDTH = 10,
  localparam int LOG_RAS_DEPTH   = $clog2(RAS_DEPTH)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  input  logic                        restore_valid,
  input  logic [LOG_RAS_DEPTH-1:0]    restore_index,
  input  logic [LOG_RAS_DEPTH:0]      restore_count,
  output logic [RAS_TARGET_WIDTH-1:0] pop_target_out,
  output logic                        empty_out,
  output logic [LOG_RAS_DEPTH-1:0]    ras_index_out,
  output logic [LOG_RAS_DEPTH:0]      ras_count_out
);

  localparam int CNT_W = LOG_RAS_DEPTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  // There is no handshake: push/pop/restore are single-cycle strobes, always accepted.
  logic [RAS_TARGET_WIDTH-1:0] arr_q [RAS_DEPTH];
  logic [RAS_TARGET_WIDTH-1:0] arr_d [RAS_DEPTH];
  logic [LOG_RAS_DEPTH-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [LOG_RAS_DEPTH-1:0]    ptr_inc, ptr_dec;

  always_comb begin
    arr_d   = arr_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ptr_inc = ptr_q + LOG_RAS_DEPTH'(1);
    ptr_dec = ptr_q - LOG_RAS_DEPTH'(1);
    if (restore_valid) begin
      ptr_d = restore_index;
      cnt_d = (restore_count > FULL_CNT) ? FULL_CNT : restore_count;
    end else if (push_valid && pop_valid) begin
      // A call and a return in the same cycle replace the top in place.
      arr_d[ptr_q] = push_target;
    end else if (push_valid) begin
      // When full, the pointer wraps onto the oldest entry and overwrites it.
      ptr_d        = ptr_inc;
      arr_d[ptr_inc] = push_target;
      if (cnt_q != FULL_CNT) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_valid && (cnt_q != '0)) begin
      ptr_d = ptr_dec;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) arr_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      arr_q <= arr_d;
    end
  end

  assign pop_target_out = arr_q[ptr_q];
  assign empty_out      = (cnt_q == '0);
  assign ras_index_out  = ptr_q;
  assign ras_count_out  = cnt_q;

endmodule

// File: tb/tb_ras.sv
// Directed testbench for the return-address stack with hand-computed expectations.
module tb_ras;

  logic       CLK;
  logic       RST;
  logic       push_valid;
  logic [9:0] push_target;
  logic       pop_valid;
  logic       restore_valid;
  logic [2:0] restore_index;
  logic [3:0] restore_count;
  logic [9:0] pop_target_out;
  logic       empty_out;
  logic [2:0] ras_index_out;
  logic [3:0] ras_count_out;

  int errors = 0;
  int checks = 0;

  ras #(.RAS_DEPTH(8), .RAS_TARGET_WIDTH(10)) dut (
    .CLK(CLK), .RST(RST),
    .push_valid(push_valid), .push_target(push_target),
    .pop_valid(pop_valid), .restore_valid(restore_valid),
    .restore_index(restore_index), .restore_count(restore_count),
    .pop_target_out(pop_target_out), .empty_out(empty_out),
    .ras_index_out(ras_index_out), .ras_count_out(ras_count_out)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    push_valid = 1'b0; push_target = '0; pop_valid = 1'b0;
    restore_valid = 1'b0; restore_index = '0; restore_count = '0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic do_push(input logic [9:0] t);
    push_valid = 1'b1; push_target = t; tick(); idle_inputs();
  endtask

  task automatic do_pop();
    pop_valid = 1'b1; tick(); idle_inputs();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (pop_target_out !== 10'h000) begin errors++; $display("FAIL reset_top got=%h exp=000", pop_target_out); end
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty_out); end
    checks++; if (ras_index_out !== 3'd0) begin errors++; $display("FAIL reset_index got=%0d exp=0", ras_index_out); end
    checks++; if (ras_count_out !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", ras_count_out); end
  endtask

  task automatic test_push_pop();
    apply_reset();
    do_push(10'h101);
    do_push(10'h202);
    checks++; if (pop_target_out !== 10'h202) begin errors++; $display("FAIL pp_top2 got=%h exp=202", pop_target_out); end
    checks++; if (ras_index_out !== 3'd2) begin errors++; $display("FAIL pp_index2 got=%0d exp=2", ras_index_out); end
    checks++; if (ras_count_out !== 4'd2) begin errors++; $display("FAIL pp_count2 got=%0d exp=2", ras_count_out); end
    checks++; if (empty_out !== 1'b0) begin errors++; $display("FAIL pp_empty2 got=%b exp=0", empty_out); end
    do_pop();
    checks++; if (pop_target_out !== 10'h101) begin errors++; $display("FAIL pp_top1 got=%h exp=101", pop_target_out); end
    checks++; if (ras_index_out !== 3'd1) begin errors++; $display("FAIL pp_index1 got=%0d exp=1", ras_index_out); end
    checks++; if (ras_count_out !== 4'd1) begin errors++; $display("FAIL pp_count1 got=%0d exp=1", ras_count_out); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 1; i <= 9; i++) do_push(10'(i));
    checks++; if (ras_count_out !== 4'd8) begin errors++; $display("FAIL wrap_count got=%0d exp=8", ras_count_out); end
    checks++; if (ras_index_out !== 3'd1) begin errors++; $display("FAIL wrap_index got=%0d exp=1", ras_index_out); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (pop_target_out !== 10'(9 - k)) begin
        errors++; $display("FAIL wrap_pop%0d_top got=%0d exp=%0d", k, pop_target_out, 9 - k);
      end
      do_pop();
    end
    checks++; if (ras_count_out !== 4'd0) begin errors++; $display("FAIL wrap_final_count got=%0d exp=0", ras_count_out); end
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL wrap_final_empty got=%b exp=1", empty_out); end
    checks++; if (ras_index_out !== 3'd1) begin errors++; $display("FAIL wrap_final_index got=%0d exp=1", ras_index_out); end
  endtask

  task automatic test_underflow_and_push_pop();
    apply_reset();
    do_pop();
    checks++; if (ras_index_out !== 3'd0) begin errors++; $display("FAIL uf_index got=%0d exp=0", ras_index_out); end
    checks++; if (ras_count_out !== 4'd0) begin errors++; $display("FAIL uf_count got=%0d exp=0", ras_count_out); end
    do_push(10'h055);
    push_valid = 1'b1; pop_valid = 1'b1; push_target = 10'h3FF;
    tick(); idle_inputs();
    checks++; if (pop_target_out !== 10'h3FF) begin errors++; $display("FAIL pp_same_top got=%h exp=3ff", pop_target_out); end
    checks++; if (ras_count_out !== 4'd1) begin errors++; $display("FAIL pp_same_count got=%0d exp=1", ras_count_out); end
    checks++; if (ras_index_out !== 3'd1) begin errors++; $display("FAIL pp_same_index got=%0d exp=1", ras_index_out); end
  endtask

  task automatic test_restore();
    apply_reset();
    do_push(10'h0A1);
    do_push(10'h0B2);
    do_push(10'h0C3);
    do_push(10'h0D4);
    do_push(10'h0E5);
    checks++; if (ras_index_out !== 3'd5) begin errors++; $display("FAIL rs_pre_index got=%0d exp=5", ras_index_out); end
    restore_valid = 1'b1; restore_index = 3'd3; restore_count = 4'd3;
    push_valid = 1'b1; push_target = 10'h2AA;
    tick(); idle_inputs();
    checks++; if (ras_index_out !== 3'd3) begin errors++; $display("FAIL rs_index got=%0d exp=3", ras_index_out); end
    checks++; if (ras_count_out !== 4'd3) begin errors++; $display("FAIL rs_count got=%0d exp=3", ras_count_out); end
    checks++; if (pop_target_out !== 10'h0C3) begin errors++; $display("FAIL rs_top got=%h exp=0c3", pop_target_out); end
    // Saturating restore with a simultaneous pop that must be ignored.
    restore_valid = 1'b1; restore_index = 3'd6; restore_count = 4'd15; pop_valid = 1'b1;
    tick(); idle_inputs();
    checks++; if (ras_count_out !== 4'd8) begin errors++; $display("FAIL rs_sat_count got=%0d exp=8", ras_count_out); end
    checks++; if (ras_index_out !== 3'd6) begin errors++; $display("FAIL rs_sat_index got=%0d exp=6", ras_index_out); end
    do_push(10'h111);
    checks++; if (ras_count_out !== 4'd8) begin errors++; $display("FAIL rs_full_push_count got=%0d exp=8", ras_count_out); end
    checks++; if (ras_index_out !== 3'd7) begin errors++; $display("FAIL rs_full_push_index got=%0d exp=7", ras_index_out); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) do_push(10'h011 + 10'(i));
    checks++; if (ras_count_out !== 4'd5) begin errors++; $display("FAIL ar_pre_count got=%0d exp=5", ras_count_out); end
    @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++; if (ras_count_out !== 4'd0) begin errors++; $display("FAIL ar_count got=%0d exp=0", ras_count_out); end
    checks++; if (ras_index_out !== 3'd0) begin errors++; $display("FAIL ar_index got=%0d exp=0", ras_index_out); end
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL ar_empty got=%b exp=1", empty_out); end
    checks++; if (pop_target_out !== 10'h000) begin errors++; $display("FAIL ar_top got=%h exp=000", pop_target_out); end
    push_valid = 1'b1; push_target = 10'h0AA;
    tick();
    checks++; if (ras_count_out !== 4'd0) begin errors++; $display("FAIL ar_push_in_reset got=%0d exp=0", ras_count_out); end
    @(negedge CLK);
    RST = 1'b0;
    tick(); idle_inputs();
    checks++; if (ras_index_out !== 3'd1) begin errors++; $display("FAIL ar_post_index got=%0d exp=1", ras_index_out); end
    checks++; if (ras_count_out !== 4'd1) begin errors++; $display("FAIL ar_post_count got=%0d exp=1", ras_count_out); end
    checks++; if (pop_target_out !== 10'h0AA) begin errors++; $display("FAIL ar_post_top got=%h exp=0aa", pop_target_out); end
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    #2;
    test_reset();
    test_push_pop();
    test_wrap();
    test_underflow_and_push_pop();
    test_restore();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
